dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU load/store path (port 0, "cpu") and a host/loader port (port 1, "host") that preloads and reads back data memory around a start/done run.
- CPU has fixed priority. A starvation counter forces a host grant after a bounded wait.
- Fully registered command path. Sits between the cpu core, the host loader and data_mem inside top_level.

Parameters:
ADDR_W, 8, data memory address width
DATA_W, 8, data word width
STARVE_LIMIT, 4, consecutive lost-arbitration cycles after which host wins; legal 1..15

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
cpu_req  in  1  cpu access request; held with command until cpu_gnt
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  cpu address
cpu_wdata  in  DATA_W  cpu write data
cpu_gnt  out  1  one-cycle pulse: cpu command issued to memory this cycle
cpu_rvalid  out  1  one-cycle pulse: cpu read data valid on rdata
host_req  in  1  host access request; held with command until host_gnt
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  one-cycle pulse: host command issued this cycle
host_rvalid  out  1  one-cycle pulse: host read data valid on rdata
rdata  out  DATA_W  read data, shared by both ports, qualified by *_rvalid
mem_en  out  1  memory command strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_en with mem_we = 0

Behaviour:
- Reset (reset = 0, asynchronous):
  - Outputs: all *_gnt, *_rvalid, mem_en and mem_we = 0; mem_addr and mem_wdata = 0.
  - Internal state: wait_cnt = 0; response tag cleared.
  - Any in-flight read is dropped, and no rvalid is produced after reset releases.
- Arbitration, evaluated every cycle t on eligible requests:
  - req_x is ineligible in a cycle where gnt_x = 1, so a held request is never double-granted.
  - force_host = host eligible and wait_cnt == STARVE_LIMIT.
  - Winner is host if force_host, or if host is the only eligible requester. Otherwise cpu if eligible. Otherwise none.
- Issue, cycle t+1 (registered):
  - gnt_winner = 1 and mem_en = 1.
  - mem_we, mem_addr and mem_wdata carry the winner's command captured at t.
  - With no winner: mem_en = 0 and mem_we = 0.
- Read return, cycle t+2, for a granted read:
  - rvalid of the owning port = 1; rdata = mem_rdata (combinational pass-through).
  - A registered 2-bit tag {valid, port} carries ownership.
  - Writes produce no rvalid.
- Throughput:
  - At most one memory command per cycle.
  - A single requester gets at most one grant every 2 cycles.
  - Back-to-back issues from alternating ports are allowed (cpu at t+1, host at t+2).
- Starvation counter wait_cnt, 4 bits:
  - Increments when host is eligible but not the winner.
  - Clears when host wins.
  - Holds when host_req = 0.
  - Saturates at STARVE_LIMIT.
- Requester rules:
  - The command must stay stable while req = 1 and gnt = 0.
  - Dropping req before gnt withdraws the request legally, and the counter holds.
- Write-then-read, same address, different ports: memory order equals issue order. A read issued at the cycle after a write returns the new data.
- Simultaneous request from both ports with wait_cnt < STARVE_LIMIT: cpu wins.

Decomposition:
- Shared package dmem_pkg:
  - typedef port_id_e {PORT_CPU = 0, PORT_HOST = 1}
  - struct mem_cmd_t {we, addr, wdata}
  - constant STARVE_CNT_W = 4
- One natural sub-module: dmem_starve_ctr, holding the saturating wait counter and force_host compare.
- Issue and response registers stay in dmem_arbiter.

Test Plan:
- Reset check: assert reset = 0 mid-read (after cpu_gnt, before cpu_rvalid) -> no cpu_rvalid after release; all outputs 0 during reset; wait_cnt = 0.
- Host-only preload then readback:
  - Writes 0x11 at addr 0x00 and 0x22 at addr 0x01.
  - Then reads addr 0x01 -> host_gnt 1 cycle after arbitration; host_rvalid 2 cycles after; rdata = 0x22.
- Simultaneous cpu read 0x00 and host read 0x01 -> cpu_gnt first, host_gnt the next cycle; cpu_rvalid with rdata = 0x11, then host_rvalid with rdata = 0x22.
- Starvation with cpu_req held high continuously and host_req high, STARVE_LIMIT = 4:
  - Host loses 4 arbitrations, then host_gnt asserts.
  - wait_cnt returns to 0 and cpu is granted again afterwards.
- Hazard: cpu writes 0x5A to addr 0x03, host reads addr 0x03 in the next arbitration -> host rdata = 0x5A; no rvalid on either port for the write.
- Held request: cpu_req held high for 6 cycles with a constant command -> exactly one cpu_gnt per 2 cycles (3 grants) and no grant on consecutive cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
// The command struct is sized by DMEM_ADDR_W/DMEM_DATA_W; the arbiter parameters default to them.
package dmem_pkg;

    localparam int DMEM_ADDR_W  = 8;
    localparam int DMEM_DATA_W  = 8;
    localparam int STARVE_CNT_W = 4;

    typedef enum logic {
        PORT_CPU  = 1'b0,
        PORT_HOST = 1'b1
    } port_id_e;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Ownership of the read currently in the memory pipeline.
    typedef struct packed {
        logic     valid;
        port_id_e port;
    } rsp_tag_t;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating count of arbitrations the host has lost in a row; raises force_host at the limit.
module dmem_starve_ctr
    import dmem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    host_elig_i,
    input  logic                    host_win_i,
    output logic                    force_host_o,
    output logic [STARVE_CNT_W-1:0] wait_cnt_o
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

    assign force_host_o = host_elig_i && (cnt_q == LIMIT);
    assign wait_cnt_o   = cnt_q;

    // A withdrawn or idle host request leaves the count untouched.
    always_comb begin
        cnt_d = cnt_q;
        if (host_win_i) begin
            cnt_d = '0;
        end else if (host_elig_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + STARVE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: cpu has fixed priority,
// the host is guaranteed service after STARVE_LIMIT lost arbitrations.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int DATA_W       = DMEM_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Handshake: a requester holds req with a stable command until it sees gnt, a one-cycle pulse
    // in the cycle its command is on the memory bus; dropping req before gnt withdraws the request.
    logic                    cpu_elig, host_elig;
    logic                    force_host, host_win, cpu_win, any_win;
    logic [STARVE_CNT_W-1:0] wait_cnt;
    mem_cmd_t                cpu_cmd, host_cmd, win_cmd;

    logic                    cpu_gnt_q, host_gnt_q;
    logic                    mem_en_q, mem_we_q;
    logic [ADDR_W-1:0]       mem_addr_q;
    logic [DATA_W-1:0]       mem_wdata_q;
    rsp_tag_t                tag_q, tag_d;

    // A request being granted this cycle was already served; it only competes again next cycle.
    assign cpu_elig  = cpu_req  && !cpu_gnt_q;
    assign host_elig = host_req && !host_gnt_q;

    assign host_win = force_host || (host_elig && !cpu_elig);
    assign cpu_win  = cpu_elig && !host_win;
    assign any_win  = cpu_win || host_win;

    assign cpu_cmd  = '{we: cpu_we,  addr: cpu_addr,  wdata: cpu_wdata};
    assign host_cmd = '{we: host_we, addr: host_addr, wdata: host_wdata};
    assign win_cmd  = host_win ? host_cmd : cpu_cmd;

    dmem_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk_i        (clk),
        .rst_ni       (reset),
        .host_elig_i  (host_elig),
        .host_win_i   (host_win),
        .force_host_o (force_host),
        .wait_cnt_o   (wait_cnt)
    );

    // The read issued this cycle returns next cycle; remember which port owns it.
    assign tag_d = '{valid: mem_en_q && !mem_we_q,
                     port:  host_gnt_q ? PORT_HOST : PORT_CPU};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_gnt_q   <= 1'b0;
            host_gnt_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tag_q       <= '0;
        end else begin
            cpu_gnt_q  <= cpu_win;
            host_gnt_q <= host_win;
            mem_en_q   <= any_win;
            mem_we_q   <= any_win && win_cmd.we;
            if (any_win) begin
                mem_addr_q  <= win_cmd.addr;
                mem_wdata_q <= win_cmd.wdata;
            end
            tag_q <= tag_d;
        end
    end

    assign cpu_gnt     = cpu_gnt_q;
    assign host_gnt    = host_gnt_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign cpu_rvalid  = tag_q.valid && (tag_q.port == PORT_CPU);
    assign host_rvalid = tag_q.valid && (tag_q.port == PORT_HOST);
    assign rdata       = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked by a scoreboard
// fed from a cycle-level reference model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int LIMIT  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              host_req = 1'b0, host_we = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [DATA_W-1:0] host_wdata = '0;
    logic              cpu_gnt, cpu_rvalid, host_gnt, host_rvalid;
    logic [DATA_W-1:0] rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .rdata       (rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Environment memory: synchronous single-port RAM, read data one cycle after mem_en.
    logic [DATA_W-1:0] ram [256] = '{default: '0};
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // ---------------- scoreboard state ----------------
    typedef struct {
        int                cyc;
        int                port;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } issue_t;

    typedef struct {
        int                cyc;
        int                port;
        logic [DATA_W-1:0] data;
    } resp_t;

    issue_t            gq[$];
    resp_t             rq[$];
    logic [DATA_W-1:0] ref_mem [256] = '{default: '0};
    int                m_last = -1;
    int                m_wait = 0;
    int                cyc = 0;
    int                checks = 0;
    int                errors = 0;

    // Written only by the stimulus process.
    int                phase = 0;
    int                timeouts = 0;
    bit                done = 1'b0;

    // Phase bookkeeping, owned by the monitor.
    int                prev_phase = 0;
    int                phase_cyc = 0;
    int                held_cnt = 0;
    int                starve_first = -1;
    int                cpu_after = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s cycle %0d actual %0h expected %0h", nm, cyc, act, exp_v);
        end
    endtask

    // ---------------- monitor + reference model ----------------
    always @(negedge clk) begin
        issue_t e;
        resp_t  r;
        bit     g_due, r_due, c_ok, h_ok;
        int     win;
        if (!reset) begin
            check("rst_cpu_gnt", cpu_gnt, 0);
            check("rst_host_gnt", host_gnt, 0);
            check("rst_cpu_rvalid", cpu_rvalid, 0);
            check("rst_host_rvalid", host_rvalid, 0);
            check("rst_mem_en", mem_en, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_wdata", mem_wdata, 0);
            check("rst_wait_cnt", dut.wait_cnt, 0);
            gq.delete();
            rq.delete();
            m_last = -1;
            m_wait = 0;
        end else begin
            g_due = (gq.size() > 0) && (gq[0].cyc == cyc);
            check("mem_en", mem_en, g_due);
            if (g_due) begin
                e = gq.pop_front();
                check("cpu_gnt", cpu_gnt, e.port == 0);
                check("host_gnt", host_gnt, e.port == 1);
                check("mem_we", mem_we, e.we);
                check("mem_addr", mem_addr, e.addr);
                if (e.we) check("mem_wdata", mem_wdata, e.wdata);
            end else begin
                check("cpu_gnt_idle", cpu_gnt, 0);
                check("host_gnt_idle", host_gnt, 0);
                check("mem_we_idle", mem_we, 0);
            end

            r_due = (rq.size() > 0) && (rq[0].cyc == cyc);
            if (r_due) begin
                r = rq.pop_front();
                check("cpu_rvalid", cpu_rvalid, r.port == 0);
                check("host_rvalid", host_rvalid, r.port == 1);
                check("rdata", rdata, r.data);
            end else begin
                check("cpu_rvalid_idle", cpu_rvalid, 0);
                check("host_rvalid_idle", host_rvalid, 0);
            end

            check("wait_cnt", dut.wait_cnt, m_wait);

            if (phase != prev_phase) begin
                if (prev_phase == 1) check("held_gnt_count", held_cnt, 3);
                if (prev_phase == 2) begin
                    check("starve_host_cycle", starve_first, 9);
                    check("starve_cpu_again", cpu_after, 1);
                end
                phase_cyc    = 0;
                held_cnt     = 0;
                starve_first = -1;
                cpu_after    = 0;
            end
            if (phase == 1 && cpu_gnt) held_cnt++;
            if (phase == 2) begin
                if (host_gnt && starve_first < 0) starve_first = phase_cyc;
                if (cpu_gnt && starve_first >= 0) cpu_after = 1;
            end
            phase_cyc++;
            prev_phase = phase;

            // Arbitrate from the rules: a port served last cycle sits this one out,
            // cpu wins ties unless the host has already lost LIMIT times.
            c_ok = cpu_req  && (m_last != 0);
            h_ok = host_req && (m_last != 1);
            if (h_ok && (m_wait == LIMIT || !c_ok)) win = 1;
            else if (c_ok)                         win = 0;
            else                                   win = -1;
            if (win == 1)  m_wait = 0;
            else if (h_ok) m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;

            if (win >= 0) begin
                e.cyc   = cyc + 1;
                e.port  = win;
                e.we    = (win == 0) ? cpu_we    : host_we;
                e.addr  = (win == 0) ? cpu_addr  : host_addr;
                e.wdata = (win == 0) ? cpu_wdata : host_wdata;
                gq.push_back(e);
                if (e.we) begin
                    ref_mem[e.addr] = e.wdata;
                end else begin
                    r.cyc  = cyc + 2;
                    r.port = win;
                    r.data = ref_mem[e.addr];
                    rq.push_back(r);
                end
            end
            m_last = win;
        end

        if (done) begin
            check("drain_empty", gq.size() + rq.size(), 0);
            check("no_timeout", timeouts, 0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        cpu_req  = 1'b0;
        host_req = 1'b0;
        repeat (n) tick();
    endtask

    task automatic cpu_cmd(input logic we, input logic [7:0] a, input logic [7:0] d);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (cpu_gnt) break;
        end
        if (!cpu_gnt) timeouts++;
        cpu_req = 1'b0;
    endtask

    task automatic host_cmd(input logic we, input logic [7:0] a, input logic [7:0] d);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (host_gnt) break;
        end
        if (!host_gnt) timeouts++;
        host_req = 1'b0;
    endtask

    task automatic both_read(input logic [7:0] ca, input logic [7:0] ha);
        cpu_req  = 1'b1; cpu_we  = 1'b0; cpu_addr  = ca;
        host_req = 1'b1; host_we = 1'b0; host_addr = ha;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (cpu_gnt)  cpu_req  = 1'b0;
            if (host_gnt) host_req = 1'b0;
            if (!cpu_req && !host_req) break;
        end
        if (cpu_req || host_req) timeouts++;
        cpu_req  = 1'b0;
        host_req = 1'b0;
    endtask

    task automatic rand_cycle(input int pc, input int ph);
        if (!cpu_req || cpu_gnt) begin
            cpu_req   = ($urandom_range(0, 99) < pc);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 8'($urandom_range(0, 7));
            cpu_wdata = 8'($urandom);
        end else if ($urandom_range(0, 99) < 5) begin
            cpu_req = 1'b0;
        end
        if (!host_req || host_gnt) begin
            host_req   = ($urandom_range(0, 99) < ph);
            host_we    = 1'($urandom_range(0, 1));
            host_addr  = 8'($urandom_range(0, 7));
            host_wdata = 8'($urandom);
        end else if ($urandom_range(0, 99) < 15) begin
            host_req = 1'b0;
        end
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1 reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        idle(2);

        // Host preload then readback.
        host_cmd(1'b1, 8'h00, 8'h11);
        host_cmd(1'b1, 8'h01, 8'h22);
        host_cmd(1'b0, 8'h01, 8'h00);
        idle(3);

        // Simultaneous reads: cpu first, host next cycle.
        both_read(8'h00, 8'h01);
        idle(3);

        // Cpu write followed by host read of the same address.
        cpu_cmd(1'b1, 8'h03, 8'h5A);
        host_cmd(1'b0, 8'h03, 8'h00);
        idle(3);

        // Held cpu request with a constant command for 6 cycles.
        phase = 1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h02;
        repeat (6) tick();
        phase = 0;
        idle(4);

        // Starvation: host only asks when cpu is also eligible.
        phase = 2;
        cpu_req  = 1'b1; cpu_we  = 1'b0; cpu_addr  = 8'h00;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h01;
        for (int k = 1; k <= 13; k++) begin
            tick();
            host_req = !cpu_gnt;
        end
        tick();
        phase = 0;
        idle(4);

        // Reset between cpu_gnt and the cpu_rvalid it would have produced.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h00;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (cpu_gnt) break;
        end
        if (!cpu_gnt) timeouts++;
        cpu_req = 1'b0;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        idle(5);

        // Random traffic with varying load.
        for (int b = 0; b < 4; b++) begin
            int pc, ph;
            pc = (b == 0) ? 30 : (b == 1) ? 90 : (b == 2) ? 60 : 95;
            ph = (b == 0) ? 30 : (b == 1) ? 50 : (b == 2) ? 90 : 95;
            for (int i = 0; i < 500; i++) rand_cycle(pc, ph);
        end
        idle(6);
        done = 1'b1;
        repeat (3) tick();
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycle %0d actual running expected finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
